// File: rtl/cmd_frame_pkg.sv
// Shared opcode constants and FSM state encoding for the command frame controller.
package cmd_frame_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;
    localparam logic [7:0] OP_BURST   = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_TX,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_ALU_TX_LO,
        ST_ALU_TX_HI,
        ST_BR_ADDR,
        ST_BR_CNT
    } state_e;

    // States that wait for an RX byte after the opcode.
    function automatic logic is_rx_state(state_e s);
        return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_ALU_A, ST_ALU_B,
                         ST_ALU_FUN, ST_BR_ADDR, ST_BR_CNT};
    endfunction

    function automatic logic is_timed_state(state_e s);
        return is_rx_state(s) || (s == ST_RD_WAIT) || (s == ST_ALU_WAIT);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter: counts while run is high, restarts on clear, flags expiry.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command frame controller: decodes RX byte frames into register, ALU and TX FIFO operations.
module cmd_frame_ctrl
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_BURST      = 4
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [DATA_WIDTH-1:0]     i_RX_P_DATA,
    input  logic                      i_RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     i_RdData,
    input  logic                      i_RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]   i_ALU_OUT,
    input  logic                      i_OUT_Valid,
    input  logic                      i_FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]     o_Address,
    output logic [DATA_WIDTH-1:0]     o_WrData,
    output logic                      o_WrEn,
    output logic                      o_RdEn,
    output logic [ALU_FUN_WIDTH-1:0]  o_ALU_FUN,
    output logic                      o_ALU_EN,
    output logic                      o_CLK_EN,
    output logic [DATA_WIDTH-1:0]     o_FIFO_DATA,
    output logic                      o_WR_INC,
    output logic                      o_clk_div_en,
    output logic                      o_frame_err
);

    state_e                     state_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      burst_cnt_q;
    logic [DATA_WIDTH-1:0]      rd_data_q;
    logic [2*DATA_WIDTH-1:0]    alu_res_q;

    logic [ADDR_WIDTH-1:0]      address_q;
    logic [DATA_WIDTH-1:0]      wr_data_q;
    logic                       wr_en_q;
    logic                       rd_en_q;
    logic [ALU_FUN_WIDTH-1:0]   alu_fun_q;
    logic                       alu_en_q;
    logic                       clk_en_q;
    logic [DATA_WIDTH-1:0]      fifo_data_q;
    logic                       wr_inc_q;
    logic                       clk_div_en_q;
    logic                       frame_err_q;

    logic tmr_run;
    logic tmr_clr;
    logic tmr_exp;

    // Counter restarts on every accepted byte and whenever the FSM leaves the timed states.
    always_comb begin
        tmr_run = is_timed_state(state_q);
        tmr_clr = !tmr_run || (i_RX_D_VLD && is_rx_state(state_q));
    end

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (i_CLK),
        .rst_i   (i_RST),
        .clear   (tmr_clr),
        .run     (tmr_run),
        .expired (tmr_exp)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            burst_cnt_q  <= '0;
            rd_data_q    <= '0;
            alu_res_q    <= '0;
            address_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            clk_en_q     <= 1'b0;
            fifo_data_q  <= '0;
            wr_inc_q     <= 1'b0;
            clk_div_en_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            wr_inc_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            clk_div_en_q <= 1'b1;

            // A received byte wins over an expiry landing in the same cycle.
            if (tmr_exp && !(i_RX_D_VLD && is_rx_state(state_q))
                && !(state_q == ST_RD_WAIT && i_RdData_Valid)
                && !(state_q == ST_ALU_WAIT && i_OUT_Valid)) begin
                frame_err_q <= 1'b1;
                clk_en_q    <= 1'b0;
                state_q     <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_RX_D_VLD) begin
                            case (i_RX_P_DATA)
                                DATA_WIDTH'(OP_WR):      state_q <= ST_WR_ADDR;
                                DATA_WIDTH'(OP_RD):      state_q <= ST_RD_ADDR;
                                DATA_WIDTH'(OP_ALU_OP):  state_q <= ST_ALU_A;
                                DATA_WIDTH'(OP_BURST):   state_q <= ST_BR_ADDR;
                                DATA_WIDTH'(OP_ALU_NOP): begin
                                    clk_en_q <= 1'b1;
                                    state_q  <= ST_ALU_FUN;
                                end
                                default:                 frame_err_q <= 1'b1;
                            endcase
                        end
                    end
                    ST_WR_ADDR: begin
                        if (i_RX_D_VLD) begin
                            addr_q  <= i_RX_P_DATA[ADDR_WIDTH-1:0];
                            state_q <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        if (i_RX_D_VLD) begin
                            wr_en_q   <= 1'b1;
                            address_q <= addr_q;
                            wr_data_q <= i_RX_P_DATA;
                            state_q   <= ST_IDLE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (i_RX_D_VLD) begin
                            addr_q      <= i_RX_P_DATA[ADDR_WIDTH-1:0];
                            burst_cnt_q <= DATA_WIDTH'(1);
                            state_q     <= ST_RD_REQ;
                        end
                    end
                    ST_RD_REQ: begin
                        rd_en_q   <= 1'b1;
                        address_q <= addr_q;
                        state_q   <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        if (i_RdData_Valid) begin
                            rd_data_q <= i_RdData;
                            state_q   <= ST_RD_TX;
                        end
                    end
                    ST_RD_TX: begin
                        if (!i_FIFO_FULL) begin
                            wr_inc_q    <= 1'b1;
                            fifo_data_q <= rd_data_q;
                            if (burst_cnt_q > DATA_WIDTH'(1)) begin
                                burst_cnt_q <= burst_cnt_q - DATA_WIDTH'(1);
                                addr_q      <= addr_q + ADDR_WIDTH'(1);
                                state_q     <= ST_RD_REQ;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_ALU_A: begin
                        if (i_RX_D_VLD) begin
                            wr_en_q   <= 1'b1;
                            address_q <= '0;
                            wr_data_q <= i_RX_P_DATA;
                            state_q   <= ST_ALU_B;
                        end
                    end
                    ST_ALU_B: begin
                        if (i_RX_D_VLD) begin
                            wr_en_q   <= 1'b1;
                            address_q <= ADDR_WIDTH'(1);
                            wr_data_q <= i_RX_P_DATA;
                            clk_en_q  <= 1'b1;
                            state_q   <= ST_ALU_FUN;
                        end
                    end
                    ST_ALU_FUN: begin
                        if (i_RX_D_VLD) begin
                            alu_fun_q <= i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
                            alu_en_q  <= 1'b1;
                            state_q   <= ST_ALU_WAIT;
                        end
                    end
                    ST_ALU_WAIT: begin
                        if (i_OUT_Valid) begin
                            alu_res_q <= i_ALU_OUT;
                            clk_en_q  <= 1'b0;
                            state_q   <= ST_ALU_TX_LO;
                        end
                    end
                    ST_ALU_TX_LO: begin
                        if (!i_FIFO_FULL) begin
                            wr_inc_q    <= 1'b1;
                            fifo_data_q <= alu_res_q[DATA_WIDTH-1:0];
                            state_q     <= ST_ALU_TX_HI;
                        end
                    end
                    ST_ALU_TX_HI: begin
                        if (!i_FIFO_FULL) begin
                            wr_inc_q    <= 1'b1;
                            fifo_data_q <= alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_BR_ADDR: begin
                        if (i_RX_D_VLD) begin
                            addr_q  <= i_RX_P_DATA[ADDR_WIDTH-1:0];
                            state_q <= ST_BR_CNT;
                        end
                    end
                    ST_BR_CNT: begin
                        if (i_RX_D_VLD) begin
                            if ((i_RX_P_DATA == '0) || (i_RX_P_DATA > DATA_WIDTH'(MAX_BURST))) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                burst_cnt_q <= i_RX_P_DATA;
                                state_q     <= ST_RD_REQ;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_Address    = address_q;
    assign o_WrData     = wr_data_q;
    assign o_WrEn       = wr_en_q;
    assign o_RdEn       = rd_en_q;
    assign o_ALU_FUN    = alu_fun_q;
    assign o_ALU_EN     = alu_en_q;
    assign o_CLK_EN     = clk_en_q;
    assign o_FIFO_DATA  = fifo_data_q;
    assign o_WR_INC     = wr_inc_q;
    assign o_clk_div_en = clk_div_en_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed self-checking bench for cmd_frame_ctrl with hand-computed expectations.
module tb_cmd_frame_ctrl;

    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic        fifo_full;

    logic [3:0]  o_Address;
    logic [7:0]  o_WrData;
    logic        o_WrEn;
    logic        o_RdEn;
    logic [3:0]  o_ALU_FUN;
    logic        o_ALU_EN;
    logic        o_CLK_EN;
    logic [7:0]  o_FIFO_DATA;
    logic        o_WR_INC;
    logic        o_clk_div_en;
    logic        o_frame_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [3:0] rd_addr_log[$];
    logic [7:0] fifo_log[$];
    int         alu_cnt;
    logic [3:0] last_fun;
    int         err_cnt;
    int         overlap_cnt;

    always #5 clk = ~clk;

    cmd_frame_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .ALU_FUN_WIDTH(4),
        .TIMEOUT_CYCLES(TO),
        .MAX_BURST(4)
    ) dut (
        .i_CLK          (clk),
        .i_RST          (rst),
        .i_RX_P_DATA    (rx_data),
        .i_RX_D_VLD     (rx_vld),
        .i_RdData       (rd_data),
        .i_RdData_Valid (rd_vld),
        .i_ALU_OUT      (alu_out),
        .i_OUT_Valid    (alu_vld),
        .i_FIFO_FULL    (fifo_full),
        .o_Address      (o_Address),
        .o_WrData       (o_WrData),
        .o_WrEn         (o_WrEn),
        .o_RdEn         (o_RdEn),
        .o_ALU_FUN      (o_ALU_FUN),
        .o_ALU_EN       (o_ALU_EN),
        .o_CLK_EN       (o_CLK_EN),
        .o_FIFO_DATA    (o_FIFO_DATA),
        .o_WR_INC       (o_WR_INC),
        .o_clk_div_en   (o_clk_div_en),
        .o_frame_err    (o_frame_err)
    );

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (o_WrEn) begin
            wr_addr_log.push_back(o_Address);
            wr_data_log.push_back(o_WrData);
        end
        if (o_RdEn) rd_addr_log.push_back(o_Address);
        if (o_ALU_EN) begin
            alu_cnt  = alu_cnt + 1;
            last_fun = o_ALU_FUN;
        end
        if (o_WR_INC) fifo_log.push_back(o_FIFO_DATA);
        if (o_frame_err) err_cnt = err_cnt + 1;
        if ((32'(o_WrEn) + 32'(o_RdEn) + 32'(o_ALU_EN) + 32'(o_WR_INC) + 32'(o_frame_err)) > 1)
            overlap_cnt = overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        tick();
        rx_vld  = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        fifo_log.delete();
        alu_cnt = 0;
        err_cnt = 0;
    endtask

    // which: 0 = o_RdEn, 1 = o_ALU_EN
    task automatic wait_for(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((which == 0 && o_RdEn) || (which == 1 && o_ALU_EN)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_fifo(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fifo_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic rd_respond(input logic [7:0] d);
        tick();
        tick();
        rd_data = d;
        rd_vld  = 1'b1;
        tick();
        rd_vld  = 1'b0;
    endtask

    function automatic logic [30:0] all_outs();
        return {o_Address, o_WrData, o_WrEn, o_RdEn, o_ALU_FUN, o_ALU_EN, o_CLK_EN,
                o_FIFO_DATA, o_WR_INC, o_clk_div_en, o_frame_err};
    endfunction

    initial begin
        bit ok;
        rst = 1'b1; rx_data = '0; rx_vld = 1'b0; rd_data = '0; rd_vld = 1'b0;
        alu_out = '0; alu_vld = 1'b0; fifo_full = 1'b0;
        overlap_cnt = 0; last_fun = '0;
        clear_logs();

        // Reset state
        tick(); tick();
        chk("reset_outputs", 32'(all_outs()), 32'h0);
        rst = 1'b0;
        tick(); tick();
        chk("clk_div_en", 32'(o_clk_div_en), 32'h1);

        // Register write AA,05,3C
        clear_logs();
        send(8'hAA); send(8'h05); send(8'h3C);
        repeat (3) tick();
        chk("wr_count", wr_addr_log.size(), 1);
        if (wr_addr_log.size() == 1) begin
            chk("wr_addr", 32'(wr_addr_log[0]), 32'h5);
            chk("wr_data", 32'(wr_data_log[0]), 32'h3C);
        end
        chk("wr_no_err", err_cnt, 0);

        // Register read BB,05 with a stray RX byte during the wait
        clear_logs();
        send(8'hBB); send(8'h05);
        wait_for(0, ok);
        chk("rd_rden_seen", 32'(ok), 32'h1);
        chk("rd_addr", 32'(o_Address), 32'h5);
        send(8'hDD);
        rd_respond(8'h5A);
        wait_fifo(1, ok);
        repeat (3) tick();
        chk("rd_fifo_count", fifo_log.size(), 1);
        if (fifo_log.size() == 1) chk("rd_fifo_byte", 32'(fifo_log[0]), 32'h5A);
        chk("rd_stray_ignored", alu_cnt, 0);

        // ALU with operands CC,07,03,00 -> 0x000A
        clear_logs();
        send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
        wait_for(1, ok);
        chk("alu_en_seen", 32'(ok), 32'h1);
        chk("alu_clk_en_wait", 32'(o_CLK_EN), 32'h1);
        chk("alu_fun", 32'(o_ALU_FUN), 32'h0);
        tick(); tick();
        alu_out = 16'h000A; alu_vld = 1'b1;
        tick();
        alu_vld = 1'b0;
        wait_fifo(2, ok);
        repeat (2) tick();
        chk("alu_clk_en_off", 32'(o_CLK_EN), 32'h0);
        chk("alu_wr_count", wr_addr_log.size(), 2);
        if (wr_addr_log.size() == 2) begin
            chk("alu_wr0", {wr_addr_log[0], wr_data_log[0]}, 32'h007);
            chk("alu_wr1", {wr_addr_log[1], wr_data_log[1]}, 32'h103);
        end
        chk("alu_fifo_count", fifo_log.size(), 2);
        if (fifo_log.size() == 2) chk("alu_fifo_bytes", {fifo_log[0], fifo_log[1]}, 32'h0A00);
        chk("alu_en_count", alu_cnt, 1);

        // ALU without operands DD,05 -> 0x1234
        clear_logs();
        send(8'hDD);
        chk("alu2_clk_en_fun", 32'(o_CLK_EN), 32'h1);
        send(8'h05);
        wait_for(1, ok);
        chk("alu2_fun", 32'(o_ALU_FUN), 32'h5);
        alu_out = 16'h1234; alu_vld = 1'b1;
        tick();
        alu_vld = 1'b0;
        wait_fifo(2, ok);
        repeat (2) tick();
        chk("alu2_no_wr", wr_addr_log.size(), 0);
        chk("alu2_fifo_count", fifo_log.size(), 2);
        if (fifo_log.size() == 2) chk("alu2_fifo_bytes", {fifo_log[0], fifo_log[1]}, 32'h3412);

        // Burst read EE,0E,03 with FIFO full for 5 cycles on the second entry
        clear_logs();
        send(8'hEE); send(8'h0E); send(8'h03);
        for (int k = 0; k < 3; k++) begin
            wait_for(0, ok);
            chk("br_rden_seen", 32'(ok), 32'h1);
            tick(); tick();
            rd_data = 8'hC1 + 8'(k); rd_vld = 1'b1;
            if (k == 1) fifo_full = 1'b1;
            tick();
            rd_vld = 1'b0;
            if (k == 1) begin
                repeat (4) tick();
                chk("br_stall", fifo_log.size(), 1);
                fifo_full = 1'b0;
            end
            wait_fifo(k + 1, ok);
            chk("br_fifo_wait", 32'(ok), 32'h1);
        end
        repeat (3) tick();
        chk("br_rd_count", rd_addr_log.size(), 3);
        if (rd_addr_log.size() == 3)
            chk("br_rd_addrs", {rd_addr_log[0], rd_addr_log[1], rd_addr_log[2]}, 32'hEF0);
        chk("br_fifo_count", fifo_log.size(), 3);
        if (fifo_log.size() == 3)
            chk("br_fifo_bytes", {fifo_log[0], fifo_log[1], fifo_log[2]}, 32'hC1C2C3);
        chk("br_no_err", err_cnt, 0);

        // Bad opcode
        clear_logs();
        send(8'h55);
        repeat (3) tick();
        chk("badop_err", err_cnt, 1);
        chk("badop_other", wr_addr_log.size() + rd_addr_log.size() + fifo_log.size() + alu_cnt, 0);

        // Burst count 0 and count above MAX_BURST
        clear_logs();
        send(8'hEE); send(8'h02); send(8'h00);
        repeat (4) tick();
        chk("br0_err", err_cnt, 1);
        chk("br0_no_rd", rd_addr_log.size(), 0);
        clear_logs();
        send(8'hEE); send(8'h02); send(8'h05);
        repeat (4) tick();
        chk("br5_err", err_cnt, 1);
        chk("br5_no_rd", rd_addr_log.size(), 0);

        // Timeout after AA,05: expiry exactly TO idle cycles later
        clear_logs();
        send(8'hAA); send(8'h05);
        repeat (TO) tick();
        chk("to_not_early", err_cnt, 0);
        tick();
        chk("to_err", err_cnt, 1);
        repeat (2) tick();
        chk("to_no_wr", wr_addr_log.size(), 0);
        clear_logs();
        send(8'hBB); send(8'h05);
        wait_for(0, ok);
        chk("to_rd_rden", 32'(ok), 32'h1);
        rd_respond(8'h77);
        wait_fifo(1, ok);
        chk("to_rd_fifo", fifo_log.size() == 1 ? 32'(fifo_log[0]) : 32'hFFFF, 32'h77);

        // Reset while in ALU_WAIT
        clear_logs();
        send(8'hDD); send(8'h01);
        wait_for(1, ok);
        chk("rst_alu_en_seen", 32'(ok), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_outputs", 32'(all_outs()), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        alu_out = 16'hBEEF; alu_vld = 1'b1;
        tick();
        alu_vld = 1'b0;
        repeat (6) tick();
        chk("rst_no_fifo", fifo_log.size(), 0);
        send(8'hAA); send(8'h03); send(8'h99);
        repeat (3) tick();
        chk("rst_first_wr", wr_addr_log.size() == 1 ? {wr_addr_log[0], wr_data_log[0]} : 32'hFFF, 32'h399);

        chk("no_strobe_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
